fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_reader_buf.sv | 60 ++++++
 rtl/fifo_reader.sv | 105 ++++++++++
 tb/tb_fifo_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side streaming adapter.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_t;

  localparam int READ_LATENCY = 1;
  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order holding buffer between the FIFO read port and the output stream.
module fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RD_BUF_DEPTH];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  // Push and pop may coincide; the occupancy check upstream keeps count within 0..2.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fifo_reader.sv
// Pulls words from a one-cycle-latency FIFO and presents them as a valid/ready stream.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  drained,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  starve_cnt
);

  rd_state_t               state_q, state_d;
  logic [READ_LATENCY-1:0] inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]    starve_cnt_q, starve_cnt_d;
  logic [DATA_WIDTH-1:0]   buf_head;
  logic [1:0]              buf_count;
  logic                    pop;
  logic [2:0]              occupancy;

  fifo_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i       (aclk),
    .srst_i      (areset),
    .push_i      (inflight_q[0]),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  assign m_valid = ~areset & (buf_count != 2'd0);
  assign m_data  = areset ? {DATA_WIDTH{1'b0}} : buf_head;
  assign pop     = m_valid & m_ready;

  // Words held after this edge: buffered plus the one landing now, minus the one leaving.
  assign occupancy  = {1'b0, buf_count} + {2'b00, inflight_q[0]} - {2'b00, pop};
  assign fifo_rd_en = enable & ~fifo_empty & ~areset & (state_q != STOP) & (occupancy <= 3'd1);
  assign inflight_d = fifo_rd_en;
  assign drained    = ~areset & (state_q == IDLE) & ~enable;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (!enable) state_d = STOP;
        else         state_d = RUN;
      end
      STOP: begin
        if (enable)                                       state_d = RUN;
        else if ((occupancy == 3'd0) && !inflight_d[0])   state_d = IDLE;
        else                                              state_d = STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if (pop) begin
      beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
    if ((state_q == RUN) && m_ready && !m_valid && (starve_cnt_q != {CNT_WIDTH{1'b1}})) begin
      starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      inflight_q   <= {READ_LATENCY{1'b0}};
      beat_cnt_q   <= {CNT_WIDTH{1'b0}};
      starve_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign beat_cnt   = beat_cnt_q;
  assign starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Randomised and directed bench for fifo_reader against a queue-based reference model.
module tb_fifo_reader;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_STOP = 2;

  logic       aclk = 1'b0;
  logic       areset, enable, fifo_empty, m_ready;
  logic [7:0] fifo_rd_data;

  logic        rd_en16, mv16, dr16;
  logic [7:0]  md16;
  logic [15:0] bc16, sc16;
  logic        rd_en4, mv4, dr4;
  logic [7:0]  md4;
  logic [3:0]  bc4, sc4;

  always #5 aclk = ~aclk;

  fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut16 (
    .aclk(aclk), .areset(areset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en16), .fifo_rd_data(fifo_rd_data), .m_valid(mv16), .m_ready(m_ready),
    .m_data(md16), .drained(dr16), .beat_cnt(bc16), .starve_cnt(sc16)
  );

  fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .aclk(aclk), .areset(areset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en4), .fifo_rd_data(fifo_rd_data), .m_valid(mv4), .m_ready(m_ready),
    .m_data(md4), .drained(dr4), .beat_cnt(bc4), .starve_cnt(sc4)
  );

  // Reference model: words held by the reader, one pending fetch, and counts.
  int         m_state, m_inflight, m_beats, m_starve;
  logic [7:0] m_buf[$];
  logic [7:0] src_q[$];
  logic [7:0] dut_out[$];
  logic       hold_empty;
  logic       e_mv, e_pop, e_rd, e_dr, rd_s;
  logic       stall_prev;
  logic [7:0] md_prev;
  int         n_cmp, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sample();
    fifo_empty = hold_empty || (src_q.size() == 0);
    #1;
    e_mv  = !areset && (m_buf.size() != 0);
    e_pop = e_mv && m_ready;
    e_rd  = enable && !fifo_empty && !areset && (m_state != S_STOP) &&
            ((m_buf.size() + m_inflight - (e_pop ? 1 : 0)) <= 1);
    e_dr  = !areset && (m_state == S_IDLE) && !enable;
    check("rd_en", rd_en16, e_rd);
    check("m_valid", mv16, e_mv);
    check("drained", dr16, e_dr);
    check("beat_cnt", bc16, m_beats % 65536);
    check("starve_cnt", sc16, (m_starve > 65535) ? 65535 : m_starve);
    check("rd_en4", rd_en4, e_rd);
    check("m_valid4", mv4, e_mv);
    check("drained4", dr4, e_dr);
    check("beat_cnt4", bc4, m_beats % 16);
    check("starve_cnt4", sc4, (m_starve > 15) ? 15 : m_starve);
    if (e_mv) begin
      check("m_data", md16, m_buf[0]);
      check("m_data4", md4, m_buf[0]);
    end
    if (areset) check("m_data_rst", md16, 8'h00);
    if (fifo_empty) check("rd_when_empty", rd_en16, 1'b0);
    if (stall_prev && !areset) begin
      check("stall_valid", mv16, 1'b1);
      check("stall_data", md16, md_prev);
    end
    stall_prev = mv16 && !m_ready;
    md_prev    = md16;
    if (mv16 && m_ready) dut_out.push_back(md16);
    rd_s = rd_en16;
  endtask

  task automatic advance();
    logic [7:0] data_now;
    data_now = fifo_rd_data;
    @(posedge aclk);
    if (areset) begin
      m_buf.delete();
      m_inflight = 0;
      m_beats    = 0;
      m_starve   = 0;
      m_state    = S_IDLE;
    end else begin
      if (m_state == S_RUN && m_ready && !e_mv) m_starve++;
      if (e_pop) begin
        void'(m_buf.pop_front());
        m_beats++;
      end
      if (m_inflight != 0) m_buf.push_back(data_now);
      m_inflight = e_rd ? 1 : 0;
      case (m_state)
        S_IDLE:  if (enable) m_state = S_RUN;
        S_RUN:   if (!enable) m_state = S_STOP;
        default: begin
          if (enable) m_state = S_RUN;
          else if (m_buf.size() == 0 && m_inflight == 0) m_state = S_IDLE;
        end
      endcase
    end
    #1;
    if (rd_s && src_q.size() != 0) fifo_rd_data = src_q.pop_front();
    else fifo_rd_data = 8'($urandom);
    @(negedge aclk);
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] next_word;
    logic [7:0] sent[$];
    areset = 1'b1; enable = 1'b0; m_ready = 1'b0; hold_empty = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = 8'h00;
    m_state = S_IDLE; m_inflight = 0; m_beats = 0; m_starve = 0;
    n_cmp = 0; n_err = 0; stall_prev = 1'b0; md_prev = 8'h00; rd_s = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);

    // Reset holds everything quiet even with data available and enable high.
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    enable = 1'b1; areset = 1'b1;
    sample();
    check("rst_rd_en", rd_en16, 1'b0);
    check("rst_valid", mv16, 1'b0);
    check("rst_drained", dr16, 1'b0);
    advance();
    areset = 1'b0; m_ready = 1'b1; dut_out.delete();

    // Streaming 0x00..0x0F: first read immediately, beats from cycle 2.
    for (int k = 0; k < 20; k++) begin
      sample();
      if (k == 0) check("first_rd", rd_en16, 1'b1);
      if (k >= 2 && k < 18) begin
        check("stream_valid", mv16, 1'b1);
        check("stream_data", md16, 8'(k - 2));
      end
      advance();
    end
    check("stream_beats", bc16, 16);
    check("stream_beats4", bc4, 0);
    src_q.push_back(8'h10);
    repeat (4) tick();
    check("wrap4", bc4, 1);
    check("beats17", bc16, 17);

    // Starvation with an empty FIFO; narrow counter saturates.
    src_q.delete();
    do_reset();
    tick();
    repeat (10) tick();
    check("starve10", sc16, 10);
    check("starve_mv", mv16, 1'b0);
    repeat (10) tick();
    check("starve20", sc16, 20);
    check("starve_sat4", sc4, 15);

    // Drain: drop enable mid-stream; remaining words still leave, no new reads.
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h20 + i));
    do_reset();
    repeat (5) tick();
    enable = 1'b0;
    base = dut_out.size();
    repeat (6) begin
      sample();
      check("drain_no_rd", rd_en16, 1'b0);
      advance();
    end
    check("drain_beats", dut_out.size() - base, 2);
    check("drained_end", dr16, 1'b1);

    // Mid-run reset discards held and in-flight words.
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h40 + i));
    enable = 1'b1;
    do_reset();
    repeat (4) tick();
    do_reset();
    check("mrst_valid", mv16, 1'b0);
    check("mrst_beats", bc16, 0);
    check("mrst_starve", sc16, 0);
    next_word = src_q[0];
    base = dut_out.size();
    repeat (10) tick();
    check("mrst_restart_cnt", (dut_out.size() > base) ? 1 : 0, 1);
    if (dut_out.size() > base) check("mrst_restart", dut_out[base], next_word);

    // Backpressure: ready pattern 1,0,0,1 over 32 words.
    src_q.delete();
    sent.delete();
    for (int i = 0; i < 32; i++) begin
      src_q.push_back(8'($urandom));
      sent.push_back(src_q[i]);
    end
    do_reset();
    dut_out.delete();
    for (int c = 0; c < 300 && dut_out.size() < 32; c++) begin
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick();
    end
    check("bp_count", dut_out.size(), 32);
    for (int i = 0; i < 32 && i < dut_out.size(); i++) check("bp_order", dut_out[i], sent[i]);

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(19, 0) == 0) enable = ~enable;
      m_ready    = ($urandom_range(2, 0) != 0);
      hold_empty = ($urandom_range(4, 0) == 0);
      areset     = ($urandom_range(149, 0) == 0);
      if (src_q.size() < 4 && $urandom_range(3, 0) == 0) src_q.push_back(8'($urandom));
      tick();
    end
    areset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
